// File: rtl/blimp_exec_pkg.sv
// Shared definitions for the BlimpV7 execute units: datapath width and shift opcodes.
package blimp_exec_pkg;

    localparam int XLEN       = 32;
    localparam int SHAMT_BITS = 5;

    typedef enum logic [1:0] {
        SHIFT_SLL  = 2'b00,
        SHIFT_SRL  = 2'b01,
        SHIFT_SRA  = 2'b10,
        SHIFT_PASS = 2'b11
    } shift_op_t;

endpackage

// File: rtl/shift_exec_stage.sv
// One registered val/rdy pipeline stage that shifts its held operand by a slice of the
// shift amount, scaled by p_step. Tags ride along untouched.
module shift_exec_stage
    import blimp_exec_pkg::*;
#(
    parameter int p_shamt_lsb = 0,
    parameter int p_shamt_msb = 2,
    parameter int p_step      = 1,
    parameter int p_tag_w     = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_val,
    output logic                               in_rdy,
    input  shift_op_t                          in_op,
    input  logic [XLEN-1:0]                    in_data,
    input  logic [p_shamt_msb-p_shamt_lsb:0]   in_shamt,
    input  logic [p_tag_w-1:0]                 in_tag,
    output logic                               out_val,
    input  logic                               out_rdy,
    output shift_op_t                          out_op,
    output logic [XLEN-1:0]                    out_data,
    output logic [p_tag_w-1:0]                 out_tag
);

    logic                             val_q;
    shift_op_t                        op_q;
    logic [XLEN-1:0]                  data_q;
    logic [p_shamt_msb-p_shamt_lsb:0] shamt_q;
    logic [p_tag_w-1:0]               tag_q;
    logic [SHAMT_BITS-1:0]            amt;

    assign in_rdy = !val_q || out_rdy;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            val_q   <= 1'b0;
            op_q    <= SHIFT_SLL;
            data_q  <= '0;
            shamt_q <= '0;
            tag_q   <= '0;
        end else if (in_rdy) begin
            val_q <= in_val;
            // Payload only changes on a real accept, so a stalled output stays stable.
            if (in_val) begin
                op_q    <= in_op;
                data_q  <= in_data;
                shamt_q <= in_shamt;
                tag_q   <= in_tag;
            end
        end
    end

    assign amt = SHAMT_BITS'(shamt_q) * SHAMT_BITS'(p_step);

    // NOTE: the default assignment ahead of the case keeps this block free of inferred latches.
    always_comb begin
        out_data = data_q;
        case (op_q)
            SHIFT_SLL:  out_data = data_q << amt;
            SHIFT_SRL:  out_data = data_q >> amt;
            SHIFT_SRA:  out_data = XLEN'($signed(data_q) >>> amt);
            SHIFT_PASS: out_data = data_q;
            default:    out_data = data_q;
        endcase
    end

    assign out_val = val_q;
    assign out_op  = op_q;
    assign out_tag = tag_q;

endmodule

// File: rtl/shift_exec_unit.sv
// Two-stage shift execute unit: coarse byte-granular shift in S1, fine bit shift in S2,
// with destination register, sequence number and PC carried alongside.
module shift_exec_unit
    import blimp_exec_pkg::*;
#(
    parameter int p_seq_num_bits  = 5,
    parameter int p_num_phys_regs = 36
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               d_val,
    output logic                               d_rdy,
    input  shift_op_t                          d_op,
    input  logic [XLEN-1:0]                    d_op1,
    input  logic [XLEN-1:0]                    d_op2,
    input  logic [$clog2(p_num_phys_regs)-1:0] d_waddr,
    input  logic [p_seq_num_bits-1:0]          d_seq_num,
    input  logic [XLEN-1:0]                    d_pc,
    output logic                               w_val,
    input  logic                               w_rdy,
    output logic [XLEN-1:0]                    w_data,
    output logic [$clog2(p_num_phys_regs)-1:0] w_waddr,
    output logic [p_seq_num_bits-1:0]          w_seq_num,
    output logic [XLEN-1:0]                    w_pc
);

    localparam int PREG_W  = $clog2(p_num_phys_regs);
    localparam int TAG_W   = PREG_W + p_seq_num_bits + XLEN;
    localparam int FINE_W  = 3;
    localparam int S1_TAG_W = TAG_W + FINE_W;

    logic                 s1_in_rdy;
    logic                 s1_val;
    logic                 s2_in_rdy;
    shift_op_t            s1_op;
    logic [XLEN-1:0]      s1_data;
    logic [S1_TAG_W-1:0]  s1_tag;
    logic [TAG_W-1:0]     s2_tag;
    shift_op_t            s2_op_unused;
    logic                 op2_hi_unused;

    assign op2_hi_unused = |d_op2[XLEN-1:SHAMT_BITS];

    // The fine shamt bits ride in S1's tag so each stage only stores the slice it consumes.
    shift_exec_stage #(
        .p_shamt_lsb (3),
        .p_shamt_msb (4),
        .p_step      (8),
        .p_tag_w     (S1_TAG_W)
    ) u_coarse (
        .clk      (clk),
        .rst      (rst),
        .in_val   (d_val),
        .in_rdy   (s1_in_rdy),
        .in_op    (d_op),
        .in_data  (d_op1),
        .in_shamt (d_op2[4:3]),
        .in_tag   ({d_op2[2:0], d_waddr, d_seq_num, d_pc}),
        .out_val  (s1_val),
        .out_rdy  (s2_in_rdy),
        .out_op   (s1_op),
        .out_data (s1_data),
        .out_tag  (s1_tag)
    );

    shift_exec_stage #(
        .p_shamt_lsb (0),
        .p_shamt_msb (2),
        .p_step      (1),
        .p_tag_w     (TAG_W)
    ) u_fine (
        .clk      (clk),
        .rst      (rst),
        .in_val   (s1_val),
        .in_rdy   (s2_in_rdy),
        .in_op    (s1_op),
        .in_data  (s1_data),
        .in_shamt (s1_tag[S1_TAG_W-1:TAG_W]),
        .in_tag   (s1_tag[TAG_W-1:0]),
        .out_val  (w_val),
        .out_rdy  (w_rdy),
        .out_op   (s2_op_unused),
        .out_data (w_data),
        .out_tag  (s2_tag)
    );

    assign {w_waddr, w_seq_num, w_pc} = s2_tag;
    assign d_rdy = s1_in_rdy && !rst;

endmodule

// File: tb/tb_shift_exec_unit.sv
// Scoreboard bench for shift_exec_unit: expected results are queued at accept and
// compared as each result leaves on the writeback side.
module tb_shift_exec_unit;
    import blimp_exec_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic [5:0]  waddr;
        logic [4:0]  seq;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        d_val = 1'b0;
    logic        d_rdy;
    shift_op_t   d_op = SHIFT_SLL;
    logic [31:0] d_op1 = '0;
    logic [31:0] d_op2 = '0;
    logic [5:0]  d_waddr = '0;
    logic [4:0]  d_seq_num = '0;
    logic [31:0] d_pc = '0;
    logic        w_val;
    logic        w_rdy = 1'b1;
    logic [31:0] w_data;
    logic [5:0]  w_waddr;
    logic [4:0]  w_seq_num;
    logic [31:0] w_pc;

    exp_t sb[$];
    int   pop_cyc[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    shift_exec_unit dut (
        .clk       (clk),
        .rst       (rst),
        .d_val     (d_val),
        .d_rdy     (d_rdy),
        .d_op      (d_op),
        .d_op1     (d_op1),
        .d_op2     (d_op2),
        .d_waddr   (d_waddr),
        .d_seq_num (d_seq_num),
        .d_pc      (d_pc),
        .w_val     (w_val),
        .w_rdy     (w_rdy),
        .w_data    (w_data),
        .w_waddr   (w_waddr),
        .w_seq_num (w_seq_num),
        .w_pc      (w_pc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] ext;
        int sh;
        sh = int'(b[4:0]);
        case (op)
            2'b00:   return a << sh;
            2'b01:   return a >> sh;
            2'b10: begin
                ext = {{32{a[31]}}, a} >> sh;
                return ext[31:0];
            end
            default: return a;
        endcase
    endfunction

    // Writeback monitor: a transfer happens at the next rising edge when both are high.
    always @(negedge clk) begin
        if (w_val && w_rdy) begin
            if (sb.size() == 0) begin
                check("sb_nonempty", 32'(sb.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("w_data", w_data, e.data);
                check("w_waddr", 32'(w_waddr), 32'(e.waddr));
                check("w_seq_num", 32'(w_seq_num), 32'(e.seq));
                check("w_pc", w_pc, e.pc);
                pop_cyc.push_back(cyc);
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] wa, input logic [4:0] sq, input logic [31:0] pc,
                        input logic [31:0] exp);
        bit done;
        done = 1'b0;
        d_op = shift_op_t'(op);
        d_op1 = a;
        d_op2 = b;
        d_waddr = wa;
        d_seq_num = sq;
        d_pc = pc;
        d_val = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (d_rdy) begin
                sb.push_back('{data: exp, waddr: wa, seq: sq, pc: pc});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("accept_timeout", 32'(done), 32'd1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_gaps(input string tag, input int n);
        check({tag, "_count"}, 32'(pop_cyc.size()), 32'(n));
        for (int i = 1; i < pop_cyc.size(); i++)
            check(tag, 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, b, e;
        logic [1:0]  op;
        exp_t        held;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_d_rdy", 32'(d_rdy), 32'd0);
        check("rst_w_val", 32'(w_val), 32'd0);
        check("rst_w_data", w_data, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_d_rdy", 32'(d_rdy), 32'd1);
        @(posedge clk);
        #1;

        // Basic SLL with latency check
        send(2'b00, 32'h1, 32'd1, 6'd5, 5'd3, 32'h200, 32'h2);
        d_val = 1'b0;
        @(negedge clk);
        check("lat_n1_w_val", 32'(w_val), 32'd0);
        @(negedge clk);
        check("lat_n2_w_val", 32'(w_val), 32'd1);
        drain("drain_basic");

        // Arithmetic, shamt masking, reserved op
        send(2'b10, 32'h8000_0000, 32'd31, 6'd1, 5'd4, 32'h204, 32'hFFFF_FFFF);
        send(2'b01, 32'h8000_0000, 32'd31, 6'd2, 5'd5, 32'h208, 32'h0000_0001);
        send(2'b10, 32'h7FFF_FFF0, 32'd4, 6'd3, 5'd6, 32'h20C, 32'h07FF_FFFF);
        send(2'b00, 32'h0000_000F, 32'hFFFF_FFE4, 6'd4, 5'd7, 32'h210, 32'h0000_00F0);
        send(2'b11, 32'h0000_1234, 32'd9, 6'd35, 5'd8, 32'h214, 32'h0000_1234);
        send(2'b10, 32'h8765_4321, 32'd13, 6'd6, 5'd9, 32'h218, 32'hFFFC_3B2A);
        d_val = 1'b0;
        drain("drain_directed");

        // Back-to-back, one result per cycle
        pop_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = $urandom;
            op = 2'($urandom_range(0, 3));
            e = ref_shift(op, a, b);
            send(op, a, b, 6'(i + 10), 5'(i), 32'h300 + 32'(4 * i), e);
        end
        d_val = 1'b0;
        drain("drain_b2b");
        check_gaps("b2b_gap", 8);

        // Backpressure: two held, third refused until writeback resumes
        w_rdy = 1'b0;
        send(2'b00, 32'h0000_00FF, 32'd8, 6'd20, 5'd16, 32'h400, 32'h0000_FF00);
        send(2'b01, 32'hF000_0000, 32'd28, 6'd21, 5'd17, 32'h404, 32'h0000_000F);
        d_op = SHIFT_SRA;
        d_op1 = 32'hC000_0000;
        d_op2 = 32'd1;
        d_waddr = 6'd22;
        d_seq_num = 5'd18;
        d_pc = 32'h408;
        held = sb[0];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_d_rdy", 32'(d_rdy), 32'd0);
            check("bp_w_val", 32'(w_val), 32'd1);
            check("bp_w_data_stable", w_data, held.data);
            check("bp_w_seq_stable", 32'(w_seq_num), 32'(held.seq));
        end
        @(posedge clk);
        #1;
        pop_cyc.delete();
        w_rdy = 1'b1;
        @(negedge clk);
        check("bp_resume_d_rdy", 32'(d_rdy), 32'd1);
        if (d_rdy) sb.push_back('{data: 32'hE000_0000, waddr: 6'd22, seq: 5'd18, pc: 32'h408});
        @(posedge clk);
        #1 d_val = 1'b0;
        drain("drain_bp");
        check_gaps("bp_gap", 3);

        // Reset with two instructions held
        w_rdy = 1'b0;
        send(2'b00, 32'hAAAA_AAAA, 32'd1, 6'd30, 5'd24, 32'h500, 32'h5555_5554);
        send(2'b00, 32'h5555_5555, 32'd1, 6'd31, 5'd25, 32'h504, 32'hAAAA_AAAA);
        d_val = 1'b0;
        @(negedge clk);
        check("pre_rst_w_val", 32'(w_val), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("in_rst_d_rdy", 32'(d_rdy), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("mid_rst_w_val", 32'(w_val), 32'd0);
        check("mid_rst_w_data", w_data, 32'd0);
        check("mid_rst_d_rdy", 32'(d_rdy), 32'd1);
        @(posedge clk);
        #1 w_rdy = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        send(2'b00, 32'h3, 32'd2, 6'd7, 5'd0, 32'h600, 32'hC);
        d_val = 1'b0;
        drain("drain_post_rst");

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shift_exec_unit.md
# shift_exec_unit

Two-stage pipelined execute unit for the BlimpV7 shift instructions (SLL, SRL, SRA, SLLI, SRLI, SRAI). It sits between issue and writeback. It accepts one renamed, operand-ready instruction per cycle over a val/rdy interface, performs the shift across two register stages, and hands the result with its destination physical register and sequence number to the writeback/commit stage. It is the unit that carries the slli directed tests.

## Interface
- p_seq_num_bits, 5, width of the in-flight sequence number
- p_num_phys_regs, 36, physical register count; preg width = $clog2(p_num_phys_regs)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- d_val  in  1  issue instruction valid
- d_rdy  out  1  unit can accept this cycle
- d_op  in  2  shift_op_t
- d_op1  in  32  value to shift
- d_op2  in  32  shift amount source; only [4:0] used (immediate shamt or rs2)
- d_waddr  in  preg width  destination physical register
- d_seq_num  in  p_seq_num_bits  sequence number
- d_pc  in  32  instruction PC, passed through
- w_val  out  1  result valid
- w_rdy  in  1  writeback accepts
- w_data  out  32  shift result
- w_waddr  out  preg width  destination physical register
- w_seq_num  out  p_seq_num_bits  sequence number
- w_pc  out  32  PC

## Operation
- Encoding of shift_op_t: SLL=2'b00, SRL=2'b01, SRA=2'b10. The reserved value 2'b11 passes d_op1 through unchanged.
- shamt = d_op2[4:0]. Bits [31:5] are ignored, with no trap.
- Stage S1 registers op, op1, shamt, and the tags. It then applies the coarse shift by shamt[4:3]*8 and registers the partial result, along with op and shamt[2:0], into S2.
- Stage S2 applies the fine shift by shamt[2:0] and drives w_data.
- Fill bits:
  - SLL: zeros on the right.
  - SRL: zeros on the left.
  - SRA: op1[31] replicated on the left, in both stages.
- Tags (waddr, seq_num, pc) travel unmodified alongside the data.
- Results leave in acceptance order. The unit never drops, duplicates or reorders an instruction.

## Timing
- Accept when d_val && d_rdy at a rising edge.
- Latency: an instruction accepted at edge N has w_val=1 from edge N+2 onward if w_rdy stayed high. It then leaves at the first edge where w_rdy=1.
- Throughput: one instruction per cycle with w_rdy held high.
- Advance rules:
  - s2_adv = !s2_val || w_rdy
  - s1_adv = !s1_val || s2_adv
  - d_rdy = s1_adv && !rst
  - d_rdy is combinationally dependent on w_rdy. Upstream must not make d_val depend on d_rdy.
- Stall: when w_val && !w_rdy, S2 holds. S1 holds if it is valid. At most 2 instructions are held.
- Simultaneous events: while full and w_rdy=1, the unit dequeues S2, moves S1 to S2 and accepts a new instruction on the same edge.
- Output stability: once w_val is asserted, w_data, w_waddr, w_seq_num and w_pc stay stable until the transfer completes.
- Reset, including mid-operation:
  - At any edge with rst=1, s1_val and s2_val clear and all data/tag registers clear to 0.
  - In-flight instructions are discarded.
  - w_val=0 and w_data/w_waddr/w_seq_num/w_pc = 0 from the edge after rst is sampled.
  - d_rdy=0 while rst=1 and 1 on the first cycle after.
- Valid-output interface rules: w_val does not wait on w_rdy. d_val/d_* are sampled only at accepting edges.

## Structure
- Shared package blimp_exec_pkg holds:
  - shift_op_t enum and its encodings
  - XLEN = 32
  - SHAMT_BITS = 5
- One sub-module, shift_exec_stage. It is a registered stage with val/rdy, a data register, a tag register, and a parameterised combinational shift over a configurable shamt slice (p_shamt_lsb, p_shamt_msb, p_step). It is instantiated twice: coarse (bits 4:3, step 8) and fine (bits 2:0, step 1).
- Top level: instantiation, tag plumbing, d_rdy logic.

## Test plan
- Basic: SLL op1=0x00000001, op2=1 -> w_data=0x00000002. The tags waddr=5, seq=3, pc=0x200 are echoed. w_val rises 2 cycles after accept.
- Arithmetic: SRA op1=0x80000000, op2=31 -> 0xFFFFFFFF. SRL with the same operands -> 0x00000001. SRA op1=0x7FFFFFF0, op2=4 -> 0x07FFFFFF.
- shamt masking: SLL op1=0x0000000F, op2=0xFFFFFFE4 (shamt 4) -> 0x000000F0. Reserved op 2'b11, op1=0x1234 -> 0x1234.
- Back-to-back: 8 instructions with seq 0..7 and w_rdy=1 -> one result per cycle, in order, correct values.
- Backpressure: w_rdy=0 for 5 cycles while 3 instructions are offered -> 2 are accepted, d_rdy=0 afterwards, and w_* is stable. When w_rdy goes high, all 3 emerge in order with no bubble.
- Reset mid-flight: with 2 instructions held, assert rst for 1 cycle -> w_val=0 and w_data=0 the next cycle, and the discarded results never appear. The next accepted SLL 0x3, 2 -> 0xC.
